// File: rtl/spine_leaf_endpoint_if.sv
// Leaf-side and crossbar-side flit signals of one spine-link endpoint.
// slave is the endpoint; master is the leaf router / crossbar peer.
interface spine_leaf_endpoint_if #(
  parameter int DWIDTH = 16
);
  logic [DWIDTH-1:0] leaf_in_data;
  logic              leaf_in_valid;
  logic [DWIDTH-1:0] leaf_out_data;
  logic              leaf_out_valid;
  logic [5:0]        leaf_out_dest_addr;
  logic [DWIDTH-1:0] sw_tx_data;
  logic [5:0]        sw_tx_dest;
  logic              sw_tx_valid;
  logic              sw_tx_ready;
  logic [DWIDTH-1:0] sw_rx_data;
  logic              sw_rx_valid;
  logic              sw_rx_ready;

  modport slave (
    input  leaf_in_data, leaf_in_valid,
    output leaf_out_data, leaf_out_valid, leaf_out_dest_addr,
    output sw_tx_data, sw_tx_dest, sw_tx_valid,
    input  sw_tx_ready,
    input  sw_rx_data, sw_rx_valid,
    output sw_rx_ready
  );

  modport master (
    output leaf_in_data, leaf_in_valid,
    input  leaf_out_data, leaf_out_valid, leaf_out_dest_addr,
    input  sw_tx_data, sw_tx_dest, sw_tx_valid,
    output sw_tx_ready,
    output sw_rx_data, sw_rx_valid,
    input  sw_rx_ready
  );
endinterface

// File: rtl/spine_leaf_endpoint.sv
// Spine-switch termination of a leaf router spine link: ingress FIFO
// toward the crossbar, paced single-pulse egress toward the leaf.
module spine_leaf_endpoint #(
  parameter int DWIDTH     = 16,
  parameter int DEPTH      = 8,
  parameter int EGRESS_GAP = 1
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  spine_leaf_endpoint_if.slave     bus,
  output logic [$clog2(DEPTH):0]   ingress_count,
  output logic [7:0]               drop_count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, drop;

  state_t            state_q;
  logic [3:0]        gap_q;
  logic [DWIDTH-1:0] out_data_q;
  logic              out_valid_q;
  logic              rdy_q;

  assign pop  = (cnt_q != '0) && bus.sw_tx_ready;
  assign push = bus.leaf_in_valid &&
                ((cnt_q < CW'(DEPTH)) || pop);
  assign drop = bus.leaf_in_valid && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + 1'b1;
      pop && !push: cnt_d = cnt_q - 1'b1;
      default:      cnt_d = cnt_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: nothing reads past the cleared pointers.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr_q] <= bus.leaf_in_data;
  end

  assign bus.sw_tx_valid = (cnt_q != '0);
  assign bus.sw_tx_data  = mem[rd_ptr_q];
  assign bus.sw_tx_dest  = bus.sw_tx_data[DWIDTH-1 -: 6];
  assign ingress_count   = cnt_q;
  assign drop_count      = drop_q;
  assign overflow        = ovf_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (bus.sw_rx_valid && bus.sw_rx_ready) begin
            out_data_q  <= bus.sw_rx_data;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          out_valid_q <= 1'b0;
          gap_q       <= 4'(EGRESS_GAP);
          state_q     <= (EGRESS_GAP == 0) ? IDLE : GAP;
        end
        GAP: begin
          gap_q <= gap_q - 1'b1;
          if (gap_q <= 4'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sw_rx_ready        = rdy_q && (state_q == IDLE);
  assign bus.leaf_out_valid     = out_valid_q;
  assign bus.leaf_out_data      = out_data_q;
  assign bus.leaf_out_dest_addr = out_data_q[DWIDTH-1 -: 6];
endmodule

// File: doc/spine_leaf_endpoint.md
# spine_leaf_endpoint

Switch-side termination of one leaf router spine link: it is the peer that drives a leaf router's `spineN_in_*` ports and consumes its `spineN_out_*` ports. Leaf-to-spine flits arrive valid-only with no backpressure, so they are buffered in a FIFO and forwarded to the spine crossbar over a valid/ready handshake. Crossbar-to-leaf flits are accepted over valid/ready and replayed to the leaf as paced single-cycle valid pulses with the destination address decoded alongside. One instance sits on each leaf-router spine port in the spine switch.

## Interface
- `DWIDTH`, default 16: flit width. The destination address is `flit[DWIDTH-1:DWIDTH-6]`.
- `DEPTH`, default 8: ingress FIFO entries. Must be a power of 2 and at least 2.
- `EGRESS_GAP`, default 1: number of idle cycles forced after each leaf-bound pulse. Range 0–15.

Ports (reset first):
- `ACLK` in 1: the single clock.
- `ARESETn` in 1: reset, asynchronous, active-low.
- `leaf_in_data` in DWIDTH: flit from the leaf's `spineN_out_data`.
- `leaf_in_valid` in 1: from the leaf's `spineN_out_valid`. A flit is offered on every cycle this is high; there is no stall.
- `leaf_out_data` out DWIDTH: to the leaf's `spineN_in_data`.
- `leaf_out_valid` out 1: to the leaf's `spineN_in_valid`.
- `leaf_out_dest_addr` out 6: to the leaf's `spineN_dest_addr`.
- `sw_tx_data` out DWIDTH: flit toward the crossbar.
- `sw_tx_dest` out 6: destination address of `sw_tx_data`.
- `sw_tx_valid` out 1 / `sw_tx_ready` in 1: handshake toward the crossbar.
- `sw_rx_data` in DWIDTH: flit from the crossbar.
- `sw_rx_valid` in 1 / `sw_rx_ready` out 1: handshake from the crossbar.
- `ingress_count` out clog2(DEPTH)+1: FIFO occupancy.
- `drop_count` out 8: number of dropped ingress flits. Saturates at 255.
- `overflow` out 1: sticky flag set by any ingress drop.

## Operation

**Ingress (leaf to crossbar)**
- Circular FIFO with read and write pointers and an occupancy counter.
- Push when `leaf_in_valid` is high and either (count < DEPTH) or (count == DEPTH and a pop happens the same cycle).
- Otherwise a valid flit is dropped. On a drop, `drop_count` increments (saturating at 255) and `overflow` is set.
- `sw_tx_valid` = (count != 0).
- `sw_tx_data` = FIFO head; `sw_tx_dest` = `sw_tx_data[DWIDTH-1:DWIDTH-6]`.
- Pop when `sw_tx_valid` and `sw_tx_ready` are both high.
- While `sw_tx_valid` is high and `sw_tx_ready` is low, `sw_tx_data` must hold stable.
- Push and pop in the same cycle leave the count unchanged.
- Pointers wrap modulo DEPTH.

**Egress (crossbar to leaf)** is a state machine with three states:
- **IDLE**
  - `sw_rx_ready` = 1.
  - When `sw_rx_valid` is high: capture `sw_rx_data` into the output register and go to SEND.
- **SEND** (exactly 1 cycle)
  - `leaf_out_valid` = 1; `leaf_out_data` = captured flit; `leaf_out_dest_addr` = captured flit `[DWIDTH-1:DWIDTH-6]`.
  - Next state is GAP, loading the gap counter with EGRESS_GAP. If EGRESS_GAP = 0, next state is IDLE instead.
- **GAP**
  - `leaf_out_valid` = 0; `sw_rx_ready` = 0.
  - The counter decrements each cycle. When it reaches 1, the next state is IDLE.
- `sw_rx_ready` is low in SEND and GAP.
- `leaf_out_data` and `leaf_out_dest_addr` hold their last values outside SEND.

**Reset**
- Applies asynchronously.
- All pointers, counters, `drop_count`, `overflow`, the gap counter and the egress data register clear to 0. The state machine goes to IDLE.
- Output values while reset is asserted:
  - `sw_tx_valid`, `leaf_out_valid`, `ingress_count`: 0.
  - `sw_rx_ready`: 0. It is qualified by a registered ready flag that rises on the first `ACLK` edge after reset release.
- Reset asserted mid-operation discards all buffered and in-flight flits. Nothing is emitted afterwards.

## Timing
- **Ingress latency:** `leaf_in_valid` sampled at edge N gives `sw_tx_valid` high in cycle N+1, provided the FIFO was empty.
- **Ingress throughput:** 1 flit per cycle when `sw_tx_ready` is held high.
- **Egress latency:** a handshake at edge N gives the `leaf_out_valid` pulse in cycle N+1.
- **Egress throughput:** 1 flit per (2 + EGRESS_GAP) cycles, i.e. one every 3 cycles at the default.
- `ingress_count`, `drop_count` and `overflow` are registered and update at the edge of the event that changes them.
- Ingress and egress are fully independent and operate concurrently.

## Test plan
- **Reset values:** assert `ARESETn` low mid-burst with the FIFO holding 3 flits. Required: `sw_tx_valid`=0, `ingress_count`=0, `sw_rx_ready`=0 during reset; `sw_rx_ready`=1 one edge after release; no stale flit ever appears.
- **Ingress pass-through:** 4 back-to-back leaf flits 0x1001..0x1004 with `sw_tx_ready`=1. Required: same order on `sw_tx_data` starting 1 cycle later; `sw_tx_dest` = 0x04 for each.
- **Overflow:** `sw_tx_ready`=0, 10 leaf flits at DEPTH=8. Required: `ingress_count`=8, `drop_count`=2, `overflow`=1; after releasing ready, the first 8 flits drain in order.
- **Full with simultaneous pop:** FIFO full and `sw_tx_ready`=1 while a leaf flit arrives. Required: no drop; count stays at 8.
- **Egress pacing:** crossbar holds `sw_rx_valid` high with flits 0xFC00 and 0x0400, EGRESS_GAP=1. Required: `leaf_out_valid` pulses at cycles 1 and 4; dest addr = 0x3F then 0x01; `sw_rx_ready` pattern 1,0,0,1.
- **Zero gap:** EGRESS_GAP=0 with continuous crossbar traffic. Required: 1 flit every 2 cycles; no flit lost or duplicated.
